// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, instruction field positions
// and the program loader state encoding.
package cpu_pkg;

    localparam int OPCODE_MSB  = 15;
    localparam int OPCODE_LSB  = 11;
    localparam int OPERAND_MSB = 10;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    typedef enum logic [1:0] {
        WAIT_HI,
        WAIT_LO,
        DONE,
        ERROR
    } loader_state_e;

endpackage

// File: rtl/loader_timeout_counter.sv
// Inter-byte idle timer: counts enabled cycles and pulses expired on the
// cycle the count reaches LIMIT-1, then restarts from zero.
module loader_timeout_counter #(
    parameter int LIMIT = 100000,
    localparam int W    = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] count_reg;

    assign expired = enable && (count_reg == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear || expired) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Packs UART byte pairs into instruction words, writes them to program memory
// at consecutive addresses and releases the CPU once an HLT word is stored.
module program_loader
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH       = 11,
    parameter int OPCODE_WIDTH   = 5,
    parameter int INSTR_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   clear,
    output logic                   pm_wr_en,
    output logic [PC_WIDTH-1:0]    pm_addr,
    output logic [INSTR_WIDTH-1:0] pm_wr_data,
    output logic                   cpu_run,
    output logic                   load_done,
    output logic                   load_error,
    output logic [PC_WIDTH:0]      prog_len,
    output logic                   timeout_flag
);

    loader_state_e          state_reg;
    logic [PC_WIDTH-1:0]    addr_reg;
    logic [7:0]             hi_reg;
    logic [INSTR_WIDTH-1:0] word;
    logic                   word_is_hlt;
    logic                   timer_clear;
    logic                   timer_enable;
    logic                   timer_expired;

    assign word        = {hi_reg, rx_data};
    assign word_is_hlt = (word[INSTR_WIDTH-1 -: OPCODE_WIDTH] == '0);

    // The timer only runs while a high byte is waiting for its partner.
    assign timer_clear  = clear || (state_reg != WAIT_LO);
    assign timer_enable = (state_reg == WAIT_LO) && !rx_valid && !clear;

    loader_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= WAIT_HI;
            addr_reg     <= '0;
            hi_reg       <= '0;
            pm_wr_en     <= 1'b0;
            pm_addr      <= '0;
            pm_wr_data   <= '0;
            cpu_run      <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            prog_len     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            pm_wr_en     <= 1'b0;
            timeout_flag <= 1'b0;
            if (clear) begin
                state_reg  <= WAIT_HI;
                addr_reg   <= '0;
                hi_reg     <= '0;
                prog_len   <= '0;
                cpu_run    <= 1'b0;
                load_done  <= 1'b0;
                load_error <= 1'b0;
            end else begin
                case (state_reg)
                    WAIT_HI: begin
                        if (rx_valid) begin
                            hi_reg    <= rx_data;
                            state_reg <= WAIT_LO;
                        end
                    end
                    WAIT_LO: begin
                        if (rx_valid) begin
                            pm_wr_en   <= 1'b1;
                            pm_addr    <= addr_reg;
                            pm_wr_data <= word;
                            prog_len   <= prog_len + 1'b1;
                            if (word_is_hlt) begin
                                state_reg <= DONE;
                            end else if (addr_reg == '1) begin
                                state_reg <= ERROR;
                            end else begin
                                addr_reg  <= addr_reg + 1'b1;
                                state_reg <= WAIT_HI;
                            end
                        end else if (timer_expired) begin
                            timeout_flag <= 1'b1;
                            state_reg    <= WAIT_HI;
                        end
                    end
                    DONE: begin
                        load_done <= 1'b1;
                        cpu_run   <= 1'b1;
                    end
                    ERROR: begin
                        load_error <= 1'b1;
                        cpu_run    <= 1'b0;
                    end
                    default: state_reg <= WAIT_HI;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a full-size instance for load/timeout/clear/
// reset sequences and a 3-bit-address instance for the memory-full case.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [7:0]  a_rx_data, b_rx_data;
    logic        a_rx_valid, b_rx_valid;
    logic        a_clear, b_clear;

    logic        a_pm_wr_en, a_cpu_run, a_load_done, a_load_error, a_timeout_flag;
    logic [10:0] a_pm_addr;
    logic [15:0] a_pm_wr_data;
    logic [11:0] a_prog_len;

    logic        b_pm_wr_en, b_cpu_run, b_load_done, b_load_error, b_timeout_flag;
    logic [2:0]  b_pm_addr;
    logic [15:0] b_pm_wr_data;
    logic [3:0]  b_prog_len;

    int total = 0;
    int bad   = 0;
    int a_wr_cnt = 0;
    int b_wr_cnt = 0;

    always #5 clk = ~clk;

    program_loader #(
        .PC_WIDTH(11), .OPCODE_WIDTH(5), .INSTR_WIDTH(16), .TIMEOUT_CYCLES(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
        .clear(a_clear), .pm_wr_en(a_pm_wr_en), .pm_addr(a_pm_addr),
        .pm_wr_data(a_pm_wr_data), .cpu_run(a_cpu_run), .load_done(a_load_done),
        .load_error(a_load_error), .prog_len(a_prog_len), .timeout_flag(a_timeout_flag)
    );

    program_loader #(
        .PC_WIDTH(3), .OPCODE_WIDTH(5), .INSTR_WIDTH(16), .TIMEOUT_CYCLES(16)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
        .clear(b_clear), .pm_wr_en(b_pm_wr_en), .pm_addr(b_pm_addr),
        .pm_wr_data(b_pm_wr_data), .cpu_run(b_cpu_run), .load_done(b_load_done),
        .load_error(b_load_error), .prog_len(b_prog_len), .timeout_flag(b_timeout_flag)
    );

    always @(posedge clk) begin
        if (a_pm_wr_en) a_wr_cnt <= a_wr_cnt + 1;
        if (b_pm_wr_en) b_wr_cnt <= b_wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Called at a negedge; the byte is presented across exactly one rising edge.
    task automatic strobe_a(input logic [7:0] b);
        a_rx_data  = b;
        a_rx_valid = 1'b1;
        @(negedge clk);
        a_rx_valid = 1'b0;
    endtask

    task automatic strobe_b(input logic [7:0] b);
        b_rx_data  = b;
        b_rx_valid = 1'b1;
        @(negedge clk);
        b_rx_valid = 1'b0;
    endtask

    task automatic chk_write_a(input string tag, input logic [10:0] addr,
                               input logic [15:0] data, input logic [11:0] len);
        chk({tag, "_wr_en"}, a_pm_wr_en, 1);
        chk({tag, "_addr"}, a_pm_addr, addr);
        chk({tag, "_data"}, a_pm_wr_data, data);
        chk({tag, "_len"}, a_prog_len, len);
        $display("write %s addr=%0h data=%04h len=%0d", tag, a_pm_addr, a_pm_wr_data, a_prog_len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;
        rst_n = 1'b0;
        a_rx_data = 8'h00; a_rx_valid = 1'b0; a_clear = 1'b0;
        b_rx_data = 8'h00; b_rx_valid = 1'b0; b_clear = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_wr_en", a_pm_wr_en, 0);
        chk("rst_addr", a_pm_addr, 0);
        chk("rst_data", a_pm_wr_data, 0);
        chk("rst_len", a_prog_len, 0);
        chk("rst_flags", {a_cpu_run, a_load_done, a_load_error, a_timeout_flag}, 0);
        chk("rst_b_flags", {b_cpu_run, b_load_done, b_load_error, b_pm_wr_en}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Memory full without HLT on the 3-bit-address instance
        for (int i = 0; i < 8; i++) begin
            strobe_b(8'h08);
            strobe_b(8'(i));
            chk("full_wr_en", b_pm_wr_en, 1);
            chk("full_addr", b_pm_addr, i);
            chk("full_data", b_pm_wr_data, {16'h0, 8'h08, 8'(i)});
            chk("full_len", b_prog_len, i + 1);
            $display("write full addr=%0d data=%04h", b_pm_addr, b_pm_wr_data);
        end
        idle(1);
        chk("full_err", b_load_error, 1);
        chk("full_run", b_cpu_run, 0);
        chk("full_done", b_load_done, 0);
        chk("full_len8", b_prog_len, 8);
        strobe_b(8'h00);
        strobe_b(8'h00);
        idle(1);
        chk("full_nowrite", b_wr_cnt, 8);
        chk("full_len_hold", b_prog_len, 8);

        // Basic three-word program ending in HLT
        strobe_a(8'h18); strobe_a(8'h05);
        chk_write_a("ldi", 11'd0, 16'h1805, 12'd1);
        idle(1);
        chk("ldi_single", a_pm_wr_en, 0);
        strobe_a(8'h20); strobe_a(8'h03);
        chk_write_a("add", 11'd1, 16'h2003, 12'd2);
        chk("add_run", a_cpu_run, 0);
        idle(1);
        strobe_a(8'h00); strobe_a(8'h00);
        chk_write_a("hlt", 11'd2, 16'h0000, 12'd3);
        chk("hlt_run_wrcycle", a_cpu_run, 0);
        idle(1);
        chk("hlt_done", a_load_done, 1);
        chk("hlt_run", a_cpu_run, 1);
        chk("hlt_err", a_load_error, 0);
        strobe_a(8'h18); strobe_a(8'h05);
        idle(1);
        chk("done_ignore_cnt", a_wr_cnt, 3);
        chk("done_ignore_len", a_prog_len, 3);

        // clear coincident with a byte: the byte is dropped
        a_clear = 1'b1; a_rx_data = 8'h18; a_rx_valid = 1'b1;
        @(negedge clk);
        a_clear = 1'b0; a_rx_valid = 1'b0;
        chk("clr_flags", {a_cpu_run, a_load_done, a_load_error}, 0);
        chk("clr_len", a_prog_len, 0);
        strobe_a(8'h21); strobe_a(8'h07);
        chk_write_a("clr_next", 11'd0, 16'h2107, 12'd1);
        idle(1);

        // Timeout of a partial word
        a_clear = 1'b1; idle(1); a_clear = 1'b0;
        strobe_a(8'h28);
        idle(15);
        chk("to_early", a_timeout_flag, 0);
        idle(1);
        chk("to_pulse", a_timeout_flag, 1);
        idle(1);
        chk("to_once", a_timeout_flag, 0);
        chk("to_nowrite", a_wr_cnt, 4);
        strobe_a(8'h00); strobe_a(8'h00);
        chk_write_a("to_hlt", 11'd0, 16'h0000, 12'd1);
        idle(1);
        chk("to_done", a_load_done, 1);

        // Back-to-back: next high byte lands in the write cycle
        a_clear = 1'b1; idle(1); a_clear = 1'b0;
        strobe_a(8'h10); strobe_a(8'h04);
        chk_write_a("b2b_first", 11'd0, 16'h1004, 12'd1);
        strobe_a(8'h30);
        chk("b2b_wr_pulse", a_pm_wr_en, 0);
        strobe_a(8'h09);
        chk_write_a("b2b_second", 11'd1, 16'h3009, 12'd2);

        // Reset while waiting for a low byte
        strobe_a(8'h48);
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", a_pm_wr_en, 0);
        chk("arst_addr", a_pm_addr, 0);
        chk("arst_data", a_pm_wr_data, 0);
        chk("arst_len", a_prog_len, 0);
        chk("arst_flags", {a_cpu_run, a_load_done, a_load_error, a_timeout_flag}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_before = a_wr_cnt;
        strobe_a(8'hAB);
        idle(1);
        chk("arst_as_hi", a_wr_cnt, wr_before);
        strobe_a(8'hCD);
        chk_write_a("arst_resv", 11'd0, 16'hABCD, 12'd1);
        idle(1);
        chk("arst_resv_nodone", a_load_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
